// File: rtl/hdmi_pattern_pkg.sv
// Shared types and constants for the HDMI test pattern generator.
// Pattern mode encoding and the colour bar table live here.
package hdmi_pattern_pkg;

  typedef enum logic [2:0] {
    BORDER  = 3'd0,
    BARS    = 3'd1,
    RAMP    = 3'd2,
    CHECKER = 3'd3,
    BOX     = 3'd4
  } pattern_mode_t;

  // {R,G,B} on/off per bar; index 0 is the leftmost bar.
  localparam logic [7:0][2:0] BAR_COLORS = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction

endpackage

// File: rtl/pattern_box_mover.sv
// One axis of the bouncing box: position steps by one per frame and
// reverses direction instead of leaving the range [0, LIMIT].
module pattern_box_mover #(
  parameter int unsigned W     = 10,
  parameter int unsigned LIMIT = 688
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         i_step,
  output logic [W-1:0] o_pos
);

  localparam logic [W-1:0] POS_LIMIT = W'(LIMIT);

  logic [W-1:0] r_pos, w_pos_d;
  logic         r_down, w_down_d;

  always_comb begin
    w_pos_d  = r_pos;
    w_down_d = r_down;
    if (i_step) begin
      if (!r_down) begin
        if (r_pos >= POS_LIMIT) begin
          w_down_d = 1'b1;
          w_pos_d  = r_pos - 1'b1;
        end else begin
          w_pos_d = r_pos + 1'b1;
        end
      end else begin
        if (r_pos == '0) begin
          w_down_d = 1'b0;
          w_pos_d  = r_pos + 1'b1;
        end else begin
          w_pos_d = r_pos - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_pos  <= '0;
      r_down <= 1'b0;
    end else begin
      r_pos  <= w_pos_d;
      r_down <= w_down_d;
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Mode-selectable test pattern source for the hdmi core rgb input.
// One registered pixel per clock; mode and animation change only at frame end.
module hdmi_pattern_gen
  import hdmi_pattern_pkg::*;
#(
  parameter int unsigned BIT_WIDTH      = 10,
  parameter int unsigned BIT_HEIGHT     = 10,
  parameter int unsigned COLOR_BITS     = 8,
  parameter int unsigned FRAME_WIDTH    = 858,
  parameter int unsigned FRAME_HEIGHT   = 525,
  parameter int unsigned SCREEN_START_X = 138,
  parameter int unsigned SCREEN_START_Y = 45,
  parameter int unsigned SCREEN_WIDTH   = 720,
  parameter int unsigned SCREEN_HEIGHT  = 480,
  parameter int unsigned BOX_SIZE       = 32,
  parameter int unsigned CHECKER_LOG2   = 4
) (
  input  logic                      clk_pixel,
  input  logic                      reset_n,
  input  logic [BIT_WIDTH-1:0]      cx,
  input  logic [BIT_HEIGHT-1:0]     cy,
  input  logic [2:0]                mode,
  output logic [3*COLOR_BITS-1:0]   rgb,
  output logic [15:0]               frame_count,
  output logic                      frame_end
);

  localparam logic [BIT_WIDTH-1:0]  X_START  = BIT_WIDTH'(SCREEN_START_X);
  localparam logic [BIT_WIDTH:0]    X_END    = (BIT_WIDTH+1)'(SCREEN_START_X + SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0]  X_LAST   = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_HEIGHT-1:0] Y_START  = BIT_HEIGHT'(SCREEN_START_Y);
  localparam logic [BIT_HEIGHT:0]   Y_END    = (BIT_HEIGHT+1)'(SCREEN_START_Y + SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT-1:0] Y_LAST   = BIT_HEIGHT'(FRAME_HEIGHT - 1);
  localparam logic [BIT_WIDTH-1:0]  BAR_LAST = BIT_WIDTH'(SCREEN_WIDTH / 8 - 1);
  localparam logic [BIT_WIDTH:0]    BOX_W    = (BIT_WIDTH+1)'(BOX_SIZE);
  localparam logic [BIT_HEIGHT:0]   BOX_H    = (BIT_HEIGHT+1)'(BOX_SIZE);
  // Ramp DDA step split into whole grey levels and a fractional remainder.
  localparam int unsigned           RAMP_Q   = (2 ** COLOR_BITS) / SCREEN_WIDTH;
  localparam logic [BIT_WIDTH:0]    RAMP_R   = (BIT_WIDTH+1)'((2 ** COLOR_BITS) % SCREEN_WIDTH);
  localparam logic [BIT_WIDTH:0]    SW_W     = (BIT_WIDTH+1)'(SCREEN_WIDTH);
  localparam logic [COLOR_BITS-1:0] C_MAX    = '1;

  function automatic logic [3*COLOR_BITS-1:0] expand(input logic [2:0] c);
    return {{COLOR_BITS{c[2]}}, {COLOR_BITS{c[1]}}, {COLOR_BITS{c[0]}}};
  endfunction

  logic [2:0]                r_mode;
  logic [15:0]               r_frame_count;
  logic [3*COLOR_BITS-1:0]   r_rgb, w_rgb;
  logic                      r_frame_end, w_frame_end;
  logic                      w_line_start, w_active, w_in_box, w_check;
  logic [BIT_WIDTH-1:0]      w_ax, w_bx;
  logic [BIT_HEIGHT-1:0]     w_ay, w_by;
  logic [BIT_WIDTH-1:0]      r_bar_col, w_bar_col, w_bar_col_d;
  logic [2:0]                r_bar_idx, w_bar_idx, w_bar_idx_d;
  logic [BIT_WIDTH-1:0]      r_acc, w_acc, w_acc_d;
  logic [BIT_WIDTH:0]        w_acc_sum;
  logic                      w_carry;
  logic [COLOR_BITS-1:0]     r_grey, w_grey, w_grey_d;
  logic [31:0]               w_grey_sum;

  assign w_frame_end  = (cx == X_LAST) && (cy == Y_LAST);
  assign w_line_start = (cx == X_START);

  pattern_box_mover #(
    .W     (BIT_WIDTH),
    .LIMIT (SCREEN_WIDTH - BOX_SIZE)
  ) u_box_x (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .i_step    (w_frame_end),
    .o_pos     (w_bx)
  );

  pattern_box_mover #(
    .W     (BIT_HEIGHT),
    .LIMIT (SCREEN_HEIGHT - BOX_SIZE)
  ) u_box_y (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .i_step    (w_frame_end),
    .o_pos     (w_by)
  );

  // Bar and ramp counters describe the current pixel; they restart at the active line start.
  always_comb begin
    w_bar_col = w_line_start ? '0 : r_bar_col;
    w_bar_idx = w_line_start ? '0 : r_bar_idx;
    w_acc     = w_line_start ? '0 : r_acc;
    w_grey    = w_line_start ? '0 : r_grey;

    w_bar_col_d = w_bar_col + 1'b1;
    w_bar_idx_d = w_bar_idx;
    if (w_bar_col == BAR_LAST) begin
      w_bar_col_d = '0;
      w_bar_idx_d = w_bar_idx + 1'b1;
    end

    w_acc_sum  = {1'b0, w_acc} + RAMP_R;
    w_carry    = (w_acc_sum >= SW_W);
    w_acc_d    = w_carry ? BIT_WIDTH'(w_acc_sum - SW_W) : BIT_WIDTH'(w_acc_sum);
    w_grey_sum = 32'(w_grey) + RAMP_Q + 32'(w_carry);
    w_grey_d   = (w_grey_sum > 32'(C_MAX)) ? C_MAX : COLOR_BITS'(w_grey_sum);
  end

  always_comb begin
    w_ax     = cx - X_START;
    w_ay     = cy - Y_START;
    w_active = (cx >= X_START) && ({1'b0, cx} < X_END) &&
               (cy >= Y_START) && ({1'b0, cy} < Y_END);
    w_in_box = ({1'b0, w_ax} >= {1'b0, w_bx}) && ({1'b0, w_ax} < {1'b0, w_bx} + BOX_W) &&
               ({1'b0, w_ay} >= {1'b0, w_by}) && ({1'b0, w_ay} < {1'b0, w_by} + BOX_H);
    w_check  = w_ax[CHECKER_LOG2] ^ w_ay[CHECKER_LOG2] ^ r_frame_count[0];
    w_rgb    = '0;
    if (w_active) begin
      case (r_mode)
        BORDER:  w_rgb = expand({cx == X_START, cy == Y_START, (cx == X_LAST) || (cy == Y_LAST)});
        BARS:    w_rgb = expand(bar_color(w_bar_idx));
        RAMP:    w_rgb = {w_grey, w_grey, w_grey};
        CHECKER: w_rgb = expand({3{w_check}});
        BOX:     w_rgb = expand({3{w_in_box}});
        default: w_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb         <= '0;
      r_frame_end   <= 1'b0;
      r_frame_count <= '0;
      r_mode        <= '0;
      r_bar_col     <= '0;
      r_bar_idx     <= '0;
      r_acc         <= '0;
      r_grey        <= '0;
    end else begin
      r_rgb       <= w_rgb;
      r_frame_end <= w_frame_end;
      r_bar_col   <= w_bar_col_d;
      r_bar_idx   <= w_bar_idx_d;
      r_acc       <= w_acc_d;
      r_grey      <= w_grey_d;
      if (w_frame_end) begin
        r_mode        <= mode;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign rgb         = r_rgb;
  assign frame_count = r_frame_count;
  assign frame_end   = r_frame_end;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: frame-level reference model checked every cycle,
// plus directed probes with literal expected pixels.
module tb_hdmi_pattern_gen;

  localparam int FW = 858, FH = 525, SSX = 138, SSY = 45, SW = 720, SH = 480;
  localparam int BOXS = 32, CL = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  cx = '0;
  logic [9:0]  cy = '0;
  logic [2:0]  mode = '0;
  logic [23:0] rgb;
  logic [15:0] fc;
  logic        fe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hdmi_pattern_gen #(
    .BIT_WIDTH      (10),
    .BIT_HEIGHT     (10),
    .COLOR_BITS     (8),
    .FRAME_WIDTH    (FW),
    .FRAME_HEIGHT   (FH),
    .SCREEN_START_X (SSX),
    .SCREEN_START_Y (SSY),
    .SCREEN_WIDTH   (SW),
    .SCREEN_HEIGHT  (SH),
    .BOX_SIZE       (BOXS),
    .CHECKER_LOG2   (CL)
  ) dut (
    .clk_pixel   (clk),
    .reset_n     (reset_n),
    .cx          (cx),
    .cy          (cy),
    .mode        (mode),
    .rgb         (rgb),
    .frame_count (fc),
    .frame_end   (fe)
  );

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] rgb3(input bit r, input bit g, input bit b);
    return {{8{r}}, {8{g}}, {8{b}}};
  endfunction

  logic [23:0] bar_tab [8];
  initial begin
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF;
    bar_tab[3] = 24'h00FF00; bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
    bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;
  end

  // Frame-level model state
  int m_mode, m_fc, m_bx, m_by, m_vx, m_vy;
  int p_cx, p_cy;
  bit p_seq;

  task automatic m_reset();
    m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_vx = 1; m_vy = 1;
    p_seq = 0; p_cx = -5; p_cy = -5;
  endtask

  task automatic m_step_box();
    int nx, ny;
    nx = m_bx + m_vx;
    if (nx > SW - BOXS || nx < 0) begin m_vx = -m_vx; nx = m_bx + m_vx; end
    ny = m_by + m_vy;
    if (ny > SH - BOXS || ny < 0) begin m_vy = -m_vy; ny = m_by + m_vy; end
    m_bx = nx; m_by = ny;
  endtask

  always @(posedge clk) begin
    int x, y, ax, ay, g;
    bit seq, known, efe;
    logic [23:0] e;
    if (!reset_n) begin
      m_reset();
    end else begin
      x = int'(cx); y = int'(cy); ax = x - SSX; ay = y - SSY;
      // Bars/ramp are only defined while the line is scanned contiguously from its start.
      seq = (x == SSX) || (p_seq && x == p_cx + 1 && y == p_cy);
      p_seq = seq; p_cx = x; p_cy = y;
      known = 1; e = '0;
      if (ax >= 0 && ax < SW && ay >= 0 && ay < SH) begin
        case (m_mode)
          0: e = rgb3(x == SSX, y == SSY, (x == FW - 1) || (y == FH - 1));
          1: if (seq) e = bar_tab[ax / (SW / 8)]; else known = 0;
          2: if (seq) begin
               g = ax * 256 / SW;
               if (g > 255) g = 255;
               e = {3{8'(g)}};
             end else known = 0;
          3: e = {24{1'(((ax >> CL) ^ (ay >> CL) ^ m_fc) & 1)}};
          4: e = {24{(ax >= m_bx && ax < m_bx + BOXS && ay >= m_by && ay < m_by + BOXS)}};
          default: e = '0;
        endcase
      end
      efe = (x == FW - 1) && (y == FH - 1);
      if (efe) begin
        m_mode = int'(mode);
        m_fc = (m_fc + 1) % 65536;
        m_step_box();
      end
      #2;
      if (reset_n) begin
        if (known) chk(rgb === e, $sformatf("pixel(%0d,%0d)", x, y), 32'(rgb), 32'(e));
        chk(fe === efe, $sformatf("frame_end(%0d,%0d)", x, y), 32'(fe), 32'(efe));
        chk(fc === 16'(m_fc), "frame_count", 32'(fc), 32'(m_fc));
      end
    end
  end

  logic [23:0] cap [0:1023];

  task automatic drive(input int x, input int y);
    @(negedge clk);
    cx = 10'(x);
    cy = 10'(y);
  endtask

  task automatic probe(input int x, input int y, input logic [23:0] e, input string nm);
    drive(x, y);
    @(posedge clk);
    #3;
    chk(rgb === e, nm, 32'(rgb), 32'(e));
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      drive(x, y);
      @(posedge clk);
      #3;
      cap[x] = rgb;
    end
  endtask

  task automatic boundary();
    drive(FW - 1, FH - 1);
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk(rgb === 24'h0, "reset rgb", 32'(rgb), 0);
    chk(fc === 16'h0, "reset frame_count", 32'(fc), 0);
    chk(fe === 1'b0, "reset frame_end", 32'(fe), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Border
    probe(138, 100, 24'hFF0000, "border left");
    probe(138, 45, 24'hFFFF00, "border corner");
    probe(857, 524, 24'h0000FF, "border last");
    chk(fe === 1'b1, "frame_end at last pixel", 32'(fe), 1);
    probe(0, 0, 24'h000000, "border blank");
    chk(fe === 1'b0, "frame_end after last pixel", 32'(fe), 0);

    // Bars
    mode = 3'd1;
    boundary();
    scan(100, 137, 857);
    chk(cap[137] === 24'h0, "bars cx137", 32'(cap[137]), 0);
    chk(cap[138] === 24'hFFFFFF, "bars ax0", 32'(cap[138]), 32'hFFFFFF);
    chk(cap[228] === 24'hFFFF00, "bars ax90", 32'(cap[228]), 32'hFFFF00);
    chk(cap[767] === 24'h0000FF, "bars ax629", 32'(cap[767]), 32'h0000FF);
    chk(cap[768] === 24'h000000, "bars ax630", 32'(cap[768]), 0);

    // Ramp
    mode = 3'd2;
    boundary();
    scan(100, 137, 857);
    chk(cap[138] === 24'h0, "ramp ax0", 32'(cap[138]), 0);
    chk(cap[857][7:0] >= 8'hFE && cap[857][23:16] == cap[857][7:0] &&
        cap[857][15:8] == cap[857][7:0], "ramp ax719", 32'(cap[857]), 32'hFEFEFE);
    ok = 1;
    for (int x = 139; x <= 857; x++) if (cap[x][7:0] < cap[x-1][7:0]) ok = 0;
    chk(ok, "ramp monotonic", 32'(ok), 1);

    // Mid-frame mode change: border holds until the frame ends
    mode = 3'd0;
    boundary();
    probe(138, 200, 24'hFF0000, "border before switch");
    mode = 3'd3;
    probe(138, 300, 24'hFF0000, "border after switch");
    probe(857, 524, 24'h0000FF, "border to frame end");
    chk(fe === 1'b1, "frame_end switch frame", 32'(fe), 1);
    chk(fc === 16'd5, "frame_count 5", 32'(fc), 5);
    probe(138, 45, 24'hFFFFFF, "checker odd frame ax0");
    probe(140, 46, 24'hFFFFFF, "checker odd frame same square");
    probe(154, 45, 24'h000000, "checker odd frame next square");
    boundary();
    probe(138, 45, 24'h000000, "checker even frame ax0");
    chk(fc === 16'd6, "frame_count 6", 32'(fc), 6);

    // Bouncing box over 900 frames
    mode = 3'd4;
    boundary();
    while (m_fc < 900) begin
      drive(SSX + m_bx, SSY + m_by);
      drive(SSX + m_bx + BOXS - 1, SSY + m_by + BOXS - 1);
      drive(SSX + m_bx - 1, SSY + m_by);
      drive(SSX + m_bx, SSY + m_by - 1);
      if (SSX + m_bx + BOXS < FW) drive(SSX + m_bx + BOXS, SSY + m_by);
      if (m_fc == 688) begin
        probe(857, 253, 24'hFFFFFF, "box x=688 right edge");
        probe(825, 253, 24'h000000, "box x=688 left outside");
      end
      if (m_fc == 689) begin
        probe(825, 252, 24'hFFFFFF, "box x=687 after bounce");
        probe(857, 252, 24'h000000, "box x=687 right clear");
      end
      if (m_fc == 896) begin
        probe(618, 45, 24'hFFFFFF, "box y=0 top row");
        probe(618, 44, 24'h000000, "box above active");
      end
      if (m_fc == 897) begin
        probe(617, 45, 24'h000000, "box y=1 row0 clear");
        probe(617, 46, 24'hFFFFFF, "box y=1 after bounce");
      end
      boundary();
    end

    // Asynchronous reset mid-line
    drive(399, 100);
    drive(400, 100);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk(rgb === 24'h0, "async reset rgb", 32'(rgb), 0);
    chk(fc === 16'h0, "async reset frame_count", 32'(fc), 0);
    mode = 3'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    probe(138, 45, 24'hFFFF00, "post-reset border mode");
    probe(138, 100, 24'hFF0000, "post-reset border left");
    boundary();
    probe(139, 46, 24'hFFFFFF, "post-reset box at 1,1");
    probe(138, 45, 24'h000000, "post-reset box origin clear");
    probe(170, 46, 24'hFFFFFF, "post-reset box right col");
    probe(171, 46, 24'h000000, "post-reset box right clear");
    chk(fc === 16'd1, "post-reset frame_count", 32'(fc), 1);

    drive(0, 0);
    @(posedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
